// File: rtl/rf_scoreboard.sv
// Parametrised register file: two combinational read ports, one write port, per-register busy scoreboard.
// Latency: reads combinational (optional same-cycle write bypass); write, busy and rsv_err update on the clk edge.
// Backpressure: none; busy bits only flag pending producers so the control unit can stall dependent reads.
module rf_scoreboard #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_REGS  = 4,
    parameter int ADDR_W    = 2,
    parameter int BYPASS    = 1,
    parameter int R0_ZERO   = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_W-1:0]    addr1,
    input  logic [ADDR_W-1:0]    addr2,
    output logic [WORD_SIZE-1:0] data1,
    output logic [WORD_SIZE-1:0] data2,
    output logic                 busy1,
    output logic                 busy2,
    input  logic                 write,
    input  logic [ADDR_W-1:0]    addr3,
    input  logic [WORD_SIZE-1:0] data3,
    input  logic                 rsv,
    input  logic [ADDR_W-1:0]    rsv_addr,
    output logic                 rsv_err,
    output logic [NUM_REGS-1:0]  busy_vec
);

    if (NUM_REGS < 2 || NUM_REGS > 64 || (NUM_REGS & (NUM_REGS - 1)) != 0 ||
        ADDR_W != $clog2(NUM_REGS)) begin : g_bad_params
        $error("rf_scoreboard: NUM_REGS must be a power of two in 2..64 and ADDR_W = log2(NUM_REGS)");
    end

    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q;
    logic [NUM_REGS-1:0]  busy_d;
    logic                 rsv_err_q;
    logic                 rsv_err_d;
    logic                 wr_en;
    logic                 rsv_en;

    // Register 0 swallows writes and reservations when hard-wired to zero.
    assign wr_en  = write && !(R0_ZERO != 0 && addr3 == '0);
    assign rsv_en = rsv && !(R0_ZERO != 0 && rsv_addr == '0);

    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[addr3] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[rsv_addr] = 1'b1;
        end
        rsv_err_d = rsv_en && busy_q[rsv_addr] && !(wr_en && addr3 == rsv_addr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q    <= '0;
            rsv_err_q <= 1'b0;
        end else begin
            if (wr_en) begin
                regs_q[addr3] <= data3;
            end
            busy_q    <= busy_d;
            rsv_err_q <= rsv_err_d;
        end
    end

    // A forwarded write clears busy unless the same edge re-reserves that register.
    always_comb begin
        data1 = regs_q[addr1];
        busy1 = busy_q[addr1];
        if (BYPASS != 0 && write && addr3 == addr1) begin
            data1 = data3;
            busy1 = rsv && rsv_addr == addr1;
        end
        if (R0_ZERO != 0 && addr1 == '0) begin
            data1 = '0;
            busy1 = 1'b0;
        end
    end

    always_comb begin
        data2 = regs_q[addr2];
        busy2 = busy_q[addr2];
        if (BYPASS != 0 && write && addr3 == addr2) begin
            data2 = data3;
            busy2 = rsv && rsv_addr == addr2;
        end
        if (R0_ZERO != 0 && addr2 == '0) begin
            data2 = '0;
            busy2 = 1'b0;
        end
    end

    assign rsv_err  = rsv_err_q;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: directed scenarios on two 8-entry configurations, then a randomized
// run of three configurations (including 32-bit x 64 registers) against a reference model.
module tb_rf_scoreboard;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Shared stimulus for the two 8-entry instances.
    logic [2:0]  s_addr1, s_addr2, s_addr3, s_rsv_addr;
    logic [15:0] s_data3;
    logic        s_write, s_rsv;
    // Stimulus for the 64-entry instance.
    logic [5:0]  c_addr1, c_addr2, c_addr3, c_rsv_addr;
    logic [31:0] c_data3;
    logic        c_write, c_rsv;

    logic [15:0] a_d1, a_d2, b_d1, b_d2;
    logic        a_b1, a_b2, b_b1, b_b2, a_err, b_err;
    logic [7:0]  a_bv, b_bv;
    logic [31:0] c_d1, c_d2;
    logic        c_b1, c_b2, c_err;
    logic [63:0] c_bv;

    int vectors = 0;
    int miscompares = 0;

    // u_a: bypass, no zero register. u_b: no bypass, zero register. u_c: wide sweep.
    rf_scoreboard #(.WORD_SIZE(16), .NUM_REGS(8), .ADDR_W(3), .BYPASS(1), .R0_ZERO(0)) u_a (
        .clk(clk), .reset_n(reset_n), .addr1(s_addr1), .addr2(s_addr2), .data1(a_d1), .data2(a_d2),
        .busy1(a_b1), .busy2(a_b2), .write(s_write), .addr3(s_addr3), .data3(s_data3),
        .rsv(s_rsv), .rsv_addr(s_rsv_addr), .rsv_err(a_err), .busy_vec(a_bv));

    rf_scoreboard #(.WORD_SIZE(16), .NUM_REGS(8), .ADDR_W(3), .BYPASS(0), .R0_ZERO(1)) u_b (
        .clk(clk), .reset_n(reset_n), .addr1(s_addr1), .addr2(s_addr2), .data1(b_d1), .data2(b_d2),
        .busy1(b_b1), .busy2(b_b2), .write(s_write), .addr3(s_addr3), .data3(s_data3),
        .rsv(s_rsv), .rsv_addr(s_rsv_addr), .rsv_err(b_err), .busy_vec(b_bv));

    rf_scoreboard #(.WORD_SIZE(32), .NUM_REGS(64), .ADDR_W(6), .BYPASS(1), .R0_ZERO(0)) u_c (
        .clk(clk), .reset_n(reset_n), .addr1(c_addr1), .addr2(c_addr2), .data1(c_d1), .data2(c_d2),
        .busy1(c_b1), .busy2(c_b2), .write(c_write), .addr3(c_addr3), .data3(c_data3),
        .rsv(c_rsv), .rsv_addr(c_rsv_addr), .rsv_err(c_err), .busy_vec(c_bv));

    // Reference model: architectural state of each instance.
    int          nr  [3] = '{8, 8, 64};
    bit          byp [3] = '{1'b1, 1'b0, 1'b1};
    bit          r0z [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] m_reg  [3][64];
    bit          m_busy [3][64];
    bit          m_err  [3];

    task automatic check(string tag, int k, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[inst %0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_err[k] = 1'b0;
            for (int i = 0; i < 64; i++) begin
                m_reg[k][i]  = '0;
                m_busy[k][i] = 1'b0;
            end
        end
    endtask

    // Returns {busy, data} seen on a read port at address a this cycle.
    function automatic logic [32:0] model_rd(int k, int a, bit wr, int wa, logic [31:0] wd, bit rs, int ra);
        if (r0z[k] && a == 0)           return '0;
        if (byp[k] && wr && wa == a)    return {rs && ra == a, wd};
        return {m_busy[k][a], m_reg[k][a]};
    endfunction

    task automatic model_edge(int k, bit wr, int wa, logic [31:0] wd, bit rs, int ra);
        bit we, re;
        we = wr && !(r0z[k] && wa == 0);
        re = rs && !(r0z[k] && ra == 0);
        m_err[k] = re && m_busy[k][ra] && !(we && wa == ra);
        if (we) begin
            m_reg[k][wa]  = wd;
            m_busy[k][wa] = 1'b0;
        end
        if (re) m_busy[k][ra] = 1'b1;
    endtask

    task automatic cmp_inst(int k, logic [31:0] d1, logic [31:0] d2, logic b1, logic b2,
                            logic [63:0] bv, logic er, bit wr, int wa, logic [31:0] wd,
                            bit rs, int ra, int a1, int a2);
        logic [32:0] e1, e2;
        logic [63:0] ebv;
        e1 = model_rd(k, a1, wr, wa, wd, rs, ra);
        e2 = model_rd(k, a2, wr, wa, wd, rs, ra);
        ebv = '0;
        for (int i = 0; i < nr[k]; i++) ebv[i] = m_busy[k][i];
        check("rnd_data1", k, 64'(d1), 64'(e1[31:0]));
        check("rnd_data2", k, 64'(d2), 64'(e2[31:0]));
        check("rnd_busy1", k, 64'(b1), 64'(e1[32]));
        check("rnd_busy2", k, 64'(b2), 64'(e2[32]));
        check("rnd_busy_vec", k, bv, ebv);
        check("rnd_rsv_err", k, 64'(er), 64'(m_err[k]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_s(bit wr, int a3, logic [15:0] d3, bit rs, int ra, int a1, int a2);
        s_write = wr; s_addr3 = 3'(a3); s_data3 = d3;
        s_rsv = rs; s_rsv_addr = 3'(ra); s_addr1 = 3'(a1); s_addr2 = 3'(a2);
    endtask

    initial begin
        reset_n = 1'b1;
        set_s(0, 0, 16'h0, 0, 0, 0, 0);
        c_write = 0; c_addr3 = '0; c_data3 = '0; c_rsv = 0; c_rsv_addr = '0; c_addr1 = '0; c_addr2 = '0;
        #1 reset_n = 1'b0;
        #1;
        check("reset_data1", 0, 64'(a_d1), 64'h0);
        check("reset_busy_vec", 0, 64'(a_bv), 64'h0);
        check("reset_rsv_err", 1, 64'(b_err), 64'h0);
        reset_n = 1'b1;
        tick();

        // Fill every register with FFFF and reserve it on the same edge.
        for (int i = 0; i < 8; i++) begin
            set_s(1, i, 16'hFFFF, 1, i, 0, 0);
            tick();
        end
        set_s(0, 0, 16'h0, 0, 0, 7, 1);
        #1;
        check("load_data1", 0, 64'(a_d1), 64'hFFFF);
        check("load_data2", 1, 64'(b_d2), 64'hFFFF);
        check("load_busy_vec", 0, 64'(a_bv), 64'hFF);
        check("load_busy_vec_r0", 1, 64'(b_bv), 64'hFE);
        reset_n = 1'b0;
        #1;
        check("async_rst_data1", 0, 64'(a_d1), 64'h0);
        check("async_rst_data2", 1, 64'(b_d2), 64'h0);
        check("async_rst_busy_vec", 0, 64'(a_bv), 64'h0);
        check("async_rst_busy1", 0, 64'(a_b1), 64'h0);
        check("async_rst_rsv_err", 0, 64'(a_err), 64'h0);
        reset_n = 1'b1;
        tick();

        // Write/read of r5 with and without bypass.
        set_s(1, 5, 16'h1234, 0, 0, 5, 5);
        #1;
        check("wr_bypass_d1", 0, 64'(a_d1), 64'h1234);
        check("wr_bypass_d2", 0, 64'(a_d2), 64'h1234);
        check("wr_nobypass_d1", 1, 64'(b_d1), 64'h0);
        tick();
        set_s(0, 0, 16'h0, 0, 0, 5, 5);
        #1;
        check("wr_next_d1", 1, 64'(b_d1), 64'h1234);
        check("wr_next_d2", 1, 64'(b_d2), 64'h1234);
        check("wr_next_a_d2", 0, 64'(a_d2), 64'h1234);

        // Reserve r3, then write it.
        set_s(0, 0, 16'h0, 1, 3, 3, 0);
        #1;
        check("rsv_comb_busy1", 0, 64'(a_b1), 64'h0);
        tick();
        set_s(0, 0, 16'h0, 0, 0, 3, 0);
        #1;
        check("rsv_busy_vec", 0, 64'(a_bv), 64'h08);
        check("rsv_busy1", 1, 64'(b_b1), 64'h1);
        check("rsv_busy1_a", 0, 64'(a_b1), 64'h1);
        set_s(1, 3, 16'hBEEF, 0, 0, 3, 0);
        #1;
        check("wb_bypass_busy1", 0, 64'(a_b1), 64'h0);
        check("wb_bypass_data1", 0, 64'(a_d1), 64'hBEEF);
        check("wb_nobypass_busy1", 1, 64'(b_b1), 64'h1);
        tick();
        set_s(0, 0, 16'h0, 0, 0, 3, 0);
        #1;
        check("wb_busy_vec", 1, 64'(b_bv), 64'h00);
        check("wb_data1", 1, 64'(b_d1), 64'hBEEF);

        // Double reservation of r2 raises a one-cycle error.
        set_s(0, 0, 16'h0, 1, 2, 2, 0);
        tick();
        check("rsv_first_err", 0, 64'(a_err), 64'h0);
        tick();
        set_s(0, 0, 16'h0, 0, 0, 2, 0);
        #1;
        check("rsv_conflict_err_a", 0, 64'(a_err), 64'h1);
        check("rsv_conflict_err_b", 1, 64'(b_err), 64'h1);
        check("rsv_conflict_vec", 0, 64'(a_bv), 64'h04);
        tick();
        check("rsv_err_pulse", 0, 64'(a_err), 64'h0);

        // Same-edge write and reserve of busy r2: new producer wins, no error.
        set_s(1, 2, 16'h0042, 1, 2, 2, 0);
        #1;
        check("wr_rsv_bypass_busy1", 0, 64'(a_b1), 64'h1);
        check("wr_rsv_bypass_data1", 0, 64'(a_d1), 64'h0042);
        tick();
        set_s(0, 0, 16'h0, 0, 0, 2, 0);
        #1;
        check("wr_rsv_busy_vec", 1, 64'(b_bv), 64'h04);
        check("wr_rsv_err", 0, 64'(a_err), 64'h0);
        check("wr_rsv_data1", 1, 64'(b_d1), 64'h0042);

        // Register 0: zero-wired on u_b, ordinary on u_a.
        set_s(1, 0, 16'hAAAA, 1, 0, 0, 0);
        #1;
        check("r0_comb_data1", 1, 64'(b_d1), 64'h0);
        check("r0_comb_busy1", 1, 64'(b_b1), 64'h0);
        check("r0_plain_bypass", 0, 64'(a_d1), 64'hAAAA);
        tick();
        set_s(0, 0, 16'h0, 1, 0, 0, 0);
        #1;
        check("r0_data1", 1, 64'(b_d1), 64'h0);
        check("r0_busy_vec", 1, 64'(b_bv), 64'h04);
        check("r0_plain_busy_vec", 0, 64'(a_bv), 64'h05);
        tick();
        set_s(0, 0, 16'h0, 0, 0, 0, 0);
        #1;
        check("r0_rsv_err", 1, 64'(b_err), 64'h0);
        check("r0_plain_rsv_err", 0, 64'(a_err), 64'h1);

        // Randomized run of all three instances against the model.
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        model_clear();
        tick();
        for (int n = 0; n < 10000; n++) begin
            set_s($urandom_range(0, 1), $urandom_range(0, 7), 16'($urandom), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            c_write = 1'($urandom); c_addr3 = 6'($urandom); c_data3 = $urandom;
            c_rsv = 1'($urandom); c_rsv_addr = 6'($urandom);
            c_addr1 = 6'($urandom); c_addr2 = ($urandom_range(0, 3) == 0) ? c_addr3 : 6'($urandom);
            #1;
            cmp_inst(0, 32'(a_d1), 32'(a_d2), a_b1, a_b2, 64'(a_bv), a_err, s_write, int'(s_addr3),
                     32'(s_data3), s_rsv, int'(s_rsv_addr), int'(s_addr1), int'(s_addr2));
            cmp_inst(1, 32'(b_d1), 32'(b_d2), b_b1, b_b2, 64'(b_bv), b_err, s_write, int'(s_addr3),
                     32'(s_data3), s_rsv, int'(s_rsv_addr), int'(s_addr1), int'(s_addr2));
            cmp_inst(2, c_d1, c_d2, c_b1, c_b2, c_bv, c_err, c_write, int'(c_addr3),
                     c_data3, c_rsv, int'(c_rsv_addr), int'(c_addr1), int'(c_addr2));
            @(posedge clk);
            model_edge(0, s_write, int'(s_addr3), 32'(s_data3), s_rsv, int'(s_rsv_addr));
            model_edge(1, s_write, int'(s_addr3), 32'(s_data3), s_rsv, int'(s_rsv_addr));
            model_edge(2, c_write, int'(c_addr3), c_data3, c_rsv, int'(c_rsv_addr));
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised general-purpose register file for the 16-bit datapath, the successor to the fixed four-entry register file. Word width and register count are configurable. Provides two combinational read ports, one synchronous write port, an optional write-to-read bypass and an optional hard-wired zero register. A per-register busy scoreboard lets the control unit mark a destination as pending at issue and clears it at writeback, so dependent reads can be stalled.

## Interface
- WORD_SIZE, 16: data width in bits.
- NUM_REGS, 4: number of registers; power of two, 2..64.
- ADDR_W, 2: address width; must equal log2(NUM_REGS), elaboration error otherwise.
- BYPASS, 1: 1 = a same-cycle write is forwarded to the read ports; 0 = reads see stored value only.
- R0_ZERO, 0: 1 = register 0 reads as zero, ignores writes and reservations.

- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- addr1  in  ADDR_W  read port 1 address.
- addr2  in  ADDR_W  read port 2 address.
- data1  out  WORD_SIZE  read port 1 data (combinational).
- data2  out  WORD_SIZE  read port 2 data (combinational).
- busy1  out  1  scoreboard bit for addr1 (combinational).
- busy2  out  1  scoreboard bit for addr2 (combinational).
- write  in  1  write enable.
- addr3  in  ADDR_W  write address.
- data3  in  WORD_SIZE  write data.
- rsv  in  1  reserve request: mark rsv_addr pending.
- rsv_addr  in  ADDR_W  register to reserve.
- rsv_err  out  1  registered pulse: previous-cycle reservation hit an already-busy register.
- busy_vec  out  NUM_REGS  full scoreboard, bit i = register i pending (registered).

## Operation
- Storage: NUM_REGS x WORD_SIZE registers plus NUM_REGS busy bits.
- Write: on rising clk with write=1, reg[addr3] <= data3; busy[addr3] <= 0.
- Reserve: on rising clk with rsv=1, busy[rsv_addr] <= 1. If busy[rsv_addr] already 1 and not being cleared by a same-cycle write to rsv_addr, rsv_err <= 1; otherwise rsv_err <= 0. The reservation still takes effect.
- Same-edge write and reserve to same address: data is written, busy ends 1 (new producer wins), rsv_err <= 0.
- Write to a non-busy register is legal; no error.
- Read: dataN = reg[addrN]. With BYPASS=1 and write=1 and addr3==addrN, dataN = data3.
- busyN = busy[addrN]. With BYPASS=1 and write=1 and addr3==addrN, busyN = 0 unless rsv=1 and rsv_addr==addrN, in which case busyN = 1. With BYPASS=0, busyN = busy[addrN] only.
- Both read ports may address the same register; both return the same value.
- R0_ZERO=1: writes to 0 discarded; data and busy for address 0 read 0 (overrides bypass); reservations to 0 ignored, never raise rsv_err; busy_vec[0] constant 0.
- The scoreboard is advisory: reads are never blocked, only flagged.

## Timing
- Reset (reset_n=0, independent of clk): all registers 0, busy_vec 0, rsv_err 0. data1/data2 read 0, busy1/busy2 read 0 (absent bypass input).
- Deassertion of reset takes effect at the next rising clk; no write or reserve is accepted on the edge where reset_n is low.
- Reset mid-operation: any pending reservation is discarded; a write on the same edge as reset assertion is lost.
- Write latency: stored value visible on read ports the cycle after the write edge; with BYPASS=1 visible combinationally in the write cycle.
- Reserve latency: busy_vec and busyN update after the edge; rsv_err valid one cycle after the offending request, high for exactly one cycle per offending request.
- No combinational path from rsv or rsv_addr to rsv_err or busy_vec.

## Test plan
- Reset: load all registers with 16'hFFFF, pulse reset_n low between edges -> data1, data2, busy_vec, rsv_err all 0 immediately, without a clock edge.
- Write/read (NUM_REGS=8): write 16'h1234 to r5, then addr1=5, addr2=5 -> both return 16'h1234 next cycle; with BYPASS=1 both return it in the write cycle, with BYPASS=0 they return the old value.
- Scoreboard: rsv r3 -> busy_vec=8'h08, busy1=1 at addr1=3; write r3 = 16'hBEEF -> busy cleared, busy1=0 in the same cycle under BYPASS=1.
- Conflict: rsv r2 twice on consecutive edges -> rsv_err=1 for one cycle after the second. Same-edge write r2 + rsv r2 -> busy stays 1, rsv_err=0.
- R0_ZERO=1: write 16'hAAAA to r0, rsv r0 -> data1=0 at addr1=0, busy_vec[0]=0, rsv_err=0.
- Parameter sweep: WORD_SIZE=32, NUM_REGS=64 -> random writes and reads against a reference model, zero mismatches over 10k cycles.
